// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and the
// baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; the reset value is
// chosen per use so a line comes out of reset at its idle level.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing-error detection and a BREAK
// state so a line held low is not decoded as a stream of zero bytes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV  = calc_div(CLK_FREQ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic s_din;

  rx_state_t  state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       tick;

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (s_din)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign tick = (div_cnt_q == '0);

  // Counters are loaded with N-1 so the sample lands exactly N cycles later.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        if (!s_din) begin
          div_cnt_d = HALF_M1;
          state_d   = START;
        end
      end
      START: begin
        if (!tick) begin
          div_cnt_d = div_cnt_q - 1'b1;
        end else if (!s_din) begin
          div_cnt_d = DIV_M1;
          state_d   = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          div_cnt_d = div_cnt_q - 1'b1;
        end else begin
          shift_d[bit_cnt_q] = s_din;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          div_cnt_d          = DIV_M1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!tick) begin
          div_cnt_d = div_cnt_q - 1'b1;
        end else if (s_din) begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: begin
        div_cnt_d = '0;
        if (s_din) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at DIV=16/HALF=8: the driver queues the
// expected byte, kind and cycle of each frame's result; the monitor pops on every pulse.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ(160),
    .BAUD    (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one frame starting at the next edge; p2 is the bit period in half
  // cycles so fractional baud skew can be modelled. n_edges>0 truncates the frame.
  task automatic send(input logic [7:0] b, input logic stop, input int p2,
                      input int n_edges, input logic expect_out);
    logic [9:0] frame;
    int         len;
    exp_t       e;
    frame = {stop, b, 1'b0};
    len   = (10 * p2 + 1) / 2;
    if (n_edges > 0) len = n_edges;
    if (expect_out) begin
      e.data = stop ? b : last_good;
      e.err  = !stop;
      e.at   = cyc + 1 + 154;
      sb.push_back(e);
      if (stop) last_good = b;
    end
    for (int j = 0; j < len; j++) begin
      din = frame[(2 * j) / p2];
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%0h expected no pulse (cycle %0d)",
                 rx_valid, frame_err, rx_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rx cycle %0d: data=%02h valid=%0b err=%0b (expected data=%02h err=%0b at %0d)",
                 cyc, rx_data, rx_valid, frame_err, e.data, e.err, e.at);
        chk("valid_flag", 32'(rx_valid), 32'(!e.err));
        chk("err_flag", 32'(frame_err), 32'(e.err));
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got %0d cycles expected completion earlier", cyc);
    finish_sim();
  end

  initial begin
    rst = 1'b1;
    din = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(5);

    // Single byte
    send(8'hA5, 1'b1, 32, 0, 1'b1);
    idle(20);

    // Back-to-back frames, no idle gap
    send(8'h00, 1'b1, 32, 0, 1'b1);
    send(8'hFF, 1'b1, 32, 0, 1'b1);
    send(8'h3C, 1'b1, 32, 0, 1'b1);
    idle(20);

    // Glitch: 4-cycle low pulse; busy only between START entry and the start sample
    begin
      int t0;
      t0 = cyc + 1;
      for (int j = 0; j < 14; j++) begin
        din = (j < 4) ? 1'b0 : 1'b1;
        @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'((j >= 2) && (j < 10)));
        chk("glitch_cycle", cyc, t0 + j);
      end
    end
    idle(20);

    // Framing error, then line held low for 5 bit times, then a good byte
    send(8'h55, 1'b0, 32, 0, 1'b1);
    din = 1'b0;
    repeat (80) @(negedge clk);
    chk("break_busy", 32'(busy), 32'h1);
    idle(20);
    chk("after_break_busy", 32'(busy), 32'h0);
    send(8'h12, 1'b1, 32, 0, 1'b1);
    idle(20);

    // Reset in the middle of data bit 4 of 0xC3
    send(8'hC3, 1'b1, 32, 88, 1'b0);
    chk("pre_reset_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    din = 1'b1;
    #1;
    chk("midrst_rx_data", 32'(rx_data), 32'h00);
    chk("midrst_rx_valid", 32'(rx_valid), 32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);
    send(8'h81, 1'b1, 32, 0, 1'b1);
    idle(20);

    // Baud skew: bit periods of 15.5, 16.5 and 17 cycles
    send(8'h96, 1'b1, 31, 0, 1'b1);
    idle(20);
    send(8'h96, 1'b1, 33, 0, 1'b1);
    idle(20);
    send(8'h96, 1'b1, 34, 0, 1'b1);
    idle(40);

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    finish_sim();
  end

endmodule
